// File: rtl/frodo_mac_if.sv
// Beat/result bus of the Frodo multi-lane MAC. Lane data is packed with lane 0 in the LSBs.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; valid with its payload stays put until accepted, and ready may depend on state only.
interface frodo_mac_if #(
  parameter int LOGQ  = 16,
  parameter int SW    = 8,
  parameter int LANES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic                  in_last;
  logic                  in_sub;
  logic [LANES*LOGQ-1:0] in_a;
  logic [LANES*SW-1:0]   in_s;
  logic [LANES*LOGQ-1:0] in_c;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*LOGQ-1:0] out_data;

  modport master (
    output in_valid, in_first, in_last, in_sub, in_a, in_s, in_c, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_first, in_last, in_sub, in_a, in_s, in_c, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/frodo_mac_lanes.sv
// Two-stage multi-lane MAC: C = c0 +/- sum(a*s) mod 2^LOGQ per lane, one beat per cycle.
// Stage 1 registers the per-lane products, stage 2 accumulates and emits on the last beat.
module frodo_mac_lanes #(
  parameter int LOGQ  = 16,
  parameter int SW    = 8,
  parameter int LANES = 4
) (
  input logic         clk,
  input logic         rst,
  frodo_mac_if.slave  bus
);
  localparam int W = LANES * LOGQ;

  logic         stall;

  logic         p_valid_q, p_valid_d;
  logic         p_first_q, p_first_d;
  logic         p_last_q,  p_last_d;
  logic         p_sub_q,   p_sub_d;
  logic [W-1:0] p_q,       p_d;
  logic [W-1:0] p_c_q,     p_c_d;
  logic [W-1:0] acc_q,     acc_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;

  logic [W-1:0] prod;
  logic [W-1:0] acc_next;

  // A held result freezes the whole pipeline, so nothing is ever dropped or overwritten.
  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LOGQ-1:0] s_ext;
    logic [LOGQ-1:0] base;

    // Only the low LOGQ bits of the product matter, so an unsigned multiply of the
    // sign-extended secret gives the same residue as a signed one.
    assign s_ext = LOGQ'($signed(bus.in_s[l*SW +: SW]));
    assign prod[l*LOGQ +: LOGQ] = bus.in_a[l*LOGQ +: LOGQ] * s_ext;

    assign base = p_first_q ? p_c_q[l*LOGQ +: LOGQ] : acc_q[l*LOGQ +: LOGQ];
    assign acc_next[l*LOGQ +: LOGQ] = p_sub_q ? (base - p_q[l*LOGQ +: LOGQ])
                                              : (base + p_q[l*LOGQ +: LOGQ]);
  end

  always_comb begin
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    p_sub_d     = p_sub_q;
    p_d         = p_q;
    p_c_d       = p_c_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (!stall) begin
      p_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        p_first_d = bus.in_first;
        p_last_d  = bus.in_last;
        p_c_d     = bus.in_c;
        p_d       = prod;
        // The direction belongs to the burst and is latched only by its first beat.
        if (bus.in_first) begin
          p_sub_d = bus.in_sub;
        end
      end

      out_valid_d = p_valid_q & p_last_q;
      if (p_valid_q) begin
        acc_d = acc_next;
        if (p_last_q) begin
          out_data_d = acc_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_sub_q     <= 1'b0;
      p_q         <= '0;
      p_c_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      p_sub_q     <= p_sub_d;
      p_q         <= p_d;
      p_c_q       <= p_c_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_frodo_mac_lanes.sv
// Directed and random-burst bench for frodo_mac_lanes (LANES=4, LOGQ=16, SW=8).
module tb_frodo_mac_lanes;
  localparam int LOGQ  = 16;
  localparam int SW    = 8;
  localparam int LANES = 4;
  localparam int W     = LANES * LOGQ;
  localparam int SWW   = LANES * SW;

  logic clk;
  logic rst;

  frodo_mac_if #(.LOGQ(LOGQ), .SW(SW), .LANES(LANES)) bus ();

  frodo_mac_lanes #(.LOGQ(LOGQ), .SW(SW), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         mon_seen = 0;
  int         cyc      = 0;
  bit         mon_en   = 0;
  bit         stream_on = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst && bus.out_valid && bus.out_ready) begin
      checks++;
      mon_seen++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h exp=none", bus.out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          failures++;
          $display("FAIL sb_data got=%h exp=%h", bus.out_data, e);
        end
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic [LOGQ-1:0] mac_p(input logic [LOGQ-1:0] a, input logic [SW-1:0] s);
    logic [LOGQ-1:0] se;
    se = {{(LOGQ-SW){s[SW-1]}}, s};
    return a * se;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_a     = '0;
    bus.in_s     = '0;
    bus.in_c     = '0;
  endtask

  task automatic send_beat(input bit first, input bit last, input bit sub,
                           input logic [W-1:0] a, input logic [SWW-1:0] s,
                           input logic [W-1:0] c);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_sub   = sub;
    bus.in_a     = a;
    bus.in_s     = s;
    bus.in_c     = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL beat_accept got=timeout exp=accepted");
    end
  endtask

  task automatic get_result(output logic [W-1:0] d, output int lat);
    d   = '0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        d   = bus.out_data;
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input int len, input bit sub);
    logic [W-1:0]   a_arr[8];
    logic [SWW-1:0] s_arr[8];
    logic [W-1:0]   c, acc;
    logic [LOGQ-1:0] p;
    c   = {$urandom, $urandom};
    acc = c;
    for (int b = 0; b < len; b++) begin
      a_arr[b] = {$urandom, $urandom};
      s_arr[b] = $urandom;
      for (int l = 0; l < LANES; l++) begin
        p = mac_p(a_arr[b][l*LOGQ +: LOGQ], s_arr[b][l*SW +: SW]);
        if (sub) acc[l*LOGQ +: LOGQ] = acc[l*LOGQ +: LOGQ] - p;
        else     acc[l*LOGQ +: LOGQ] = acc[l*LOGQ +: LOGQ] + p;
      end
    end
    exp_q.push_back(acc);
    for (int b = 0; b < len; b++) begin
      send_beat(b == 0, b == len - 1, (b == 0) ? sub : ~sub, a_arr[b], s_arr[b],
                (b == 0) ? c : {$urandom, $urandom});
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_empty got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [W-1:0] d;
    int lat;
    send_beat(1, 1, 0, {16'h0001, 16'h8000, 16'h0002, 16'h1234},
              {8'h80, 8'h02, 8'h03, 8'hFD},
              {16'h0000, 16'h0000, 16'h0001, 16'h0010});
    drive_idle();
    get_result(d, lat);
    checks++;
    if (d !== {16'hFF80, 16'h0000, 16'h0007, 16'hC974}) begin
      failures++;
      $display("FAIL single_data got=%h exp=%h", d, {16'hFF80, 16'h0000, 16'h0007, 16'hC974});
    end
    checks++;
    if (lat != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] d;
    int lat;
    for (int b = 0; b < 3; b++) begin
      send_beat(b == 0, b == 2, 0, {16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF},
                {8'h07, 8'h07, 8'h7F, 8'h07},
                (b == 0) ? {16'h0005, 16'h0005, 16'h0000, 16'h0005} : {LANES{16'hDEAD}});
    end
    drive_idle();
    get_result(d, lat);
    checks++;
    if (d !== {16'hFFF0, 16'hFFF0, 16'h017D, 16'hFFF0}) begin
      failures++;
      $display("FAIL wrap_data got=%h exp=%h", d, {16'hFFF0, 16'hFFF0, 16'h017D, 16'hFFF0});
    end
  endtask

  task automatic test_subtract();
    logic [W-1:0] d;
    int lat;
    send_beat(1, 0, 1, {16'd100, 16'd100, 16'd7, 16'd100}, {8'hFE, 8'hFE, 8'h03, 8'hFE},
              {16'd1000, 16'd1000, 16'd0, 16'd1000});
    send_beat(0, 1, 0, {16'd50, 16'd50, 16'd1, 16'd50}, {8'h04, 8'h04, 8'h01, 8'h04},
              {LANES{16'h5555}});
    drive_idle();
    get_result(d, lat);
    checks++;
    if (d !== {16'h03E8, 16'h03E8, 16'hFFEA, 16'h03E8}) begin
      failures++;
      $display("FAIL sub_data got=%h exp=%h", d, {16'h03E8, 16'h03E8, 16'hFFEA, 16'h03E8});
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] d;
    int lat;
    send_beat(1, 0, 0, {LANES{16'd5}}, {LANES{8'd5}}, {LANES{16'd7}});
    send_beat(1, 1, 0, {LANES{16'd2}}, {LANES{8'd2}}, {LANES{16'd1}});
    drive_idle();
    get_result(d, lat);
    checks++;
    if (d !== {LANES{16'h0005}}) begin
      failures++;
      $display("FAIL restart_data got=%h exp=%h", d, {LANES{16'h0005}});
    end
  endtask

  task automatic test_reset_in_flight();
    logic [W-1:0] d;
    int lat;
    bus.out_ready = 1'b0;
    send_beat(1, 1, 0, {LANES{16'd3}}, {LANES{8'd5}}, {LANES{16'd1}});
    send_beat(1, 0, 1, {LANES{16'd9}}, {LANES{8'd9}}, {LANES{16'd9}});
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {LANES{16'h0010}}) begin
      failures++;
      $display("FAIL flight_pending got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, {LANES{16'h0010}});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flight_rst_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin failures++; $display("FAIL flight_rst_data got=%h exp=0", bus.out_data); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flight_rst_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_beat(1, 1, 0, {16'h0001, 16'h8000, 16'h0002, 16'h1234},
              {8'h80, 8'h02, 8'h03, 8'hFD},
              {16'h0000, 16'h0000, 16'h0001, 16'h0010});
    drive_idle();
    get_result(d, lat);
    checks++;
    if (d !== {16'hFF80, 16'h0000, 16'h0007, 16'hC974}) begin
      failures++;
      $display("FAIL flight_after got=%h exp=%h", d, {16'hFF80, 16'h0000, 16'h0007, 16'hC974});
    end
  endtask

  task automatic test_backpressure();
    mon_en = 1;
    bus.out_ready = 1'b0;
    exp_q.push_back({LANES{16'h0010}});
    exp_q.push_back({LANES{16'hFFF6}});
    exp_q.push_back({LANES{16'h1001}});
    send_beat(1, 1, 0, {LANES{16'd3}}, {LANES{8'd5}}, {LANES{16'd1}});
    send_beat(1, 1, 0, {LANES{16'd10}}, {LANES{8'hFF}}, {LANES{16'd0}});
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_sub   = 1'b0;
    bus.in_a     = {LANES{16'h0100}};
    bus.in_s     = {LANES{8'h10}};
    bus.in_c     = {LANES{16'h0001}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); end
      checks++;
      if (bus.out_data !== {LANES{16'h0010}}) begin
        failures++;
        $display("FAIL bp_out_data got=%h exp=%h", bus.out_data, {LANES{16'h0010}});
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_beat(1, 1, 0, {LANES{16'h0100}}, {LANES{8'h10}}, {LANES{16'h0001}});
    drive_idle();
    drain(20);
    mon_en = 0;
  endtask

  task automatic test_back_to_back();
    int start, seen0;
    mon_en = 1;
    bus.out_ready = 1'b1;
    seen0 = mon_seen;
    start = cyc;
    send_burst(2, 0);
    send_burst(1, 1);
    send_burst(3, 0);
    checks++;
    if (cyc - start != 6) begin failures++; $display("FAIL b2b_cycles got=%0d exp=6", cyc - start); end
    drive_idle();
    drain(20);
    checks++;
    if (mon_seen - seen0 != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", mon_seen - seen0); end
    mon_en = 0;
  endtask

  task automatic test_stream();
    int seen0;
    mon_en = 1;
    seen0 = mon_seen;
    stream_on = 1;
    fork
      begin
        while (stream_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 20; n++) begin
      send_burst($urandom_range(1, 8), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        @(posedge clk);
        #1;
      end
    end
    drive_idle();
    stream_on = 0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain(300);
    checks++;
    if (mon_seen - seen0 != 20) begin failures++; $display("FAIL stream_count got=%0d exp=20", mon_seen - seen0); end
    mon_en = 0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_wrap();
    test_subtract();
    test_restart();
    test_reset_in_flight();
    test_backpressure();
    test_back_to_back();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
